m_multicycle_ctrl: RTL and testbench
====================================

// Module: m_multicycle_ctrl
// PURPOSE
//  Multicycle control FSM that sequences the RV32I subset datapath (RF, ALU, imm gen, one shared m_mem)
//  over several cycles per instruction, replacing the single-cycle decoder. Drives mux selects, write
//  enables and the ALU code. Handshakes with the shared memory, counts retired instructions and traps
//  on illegal opcodes or a memory timeout. The datapath latches IR/oldPC on ir_write and ALUOut/MDR every cycle.
// PARAMETERS
//  CNT_W        32  width of retired-instruction counter (wraps mod 2^CNT_W)
//  MEM_TIMEOUT  0   max cycles a mem_req waits for mem_ready before trapping; 0 = wait forever
// PORTS
//  w_clk          in   1      clock, rising edge
//  w_rst          in   1      reset, asynchronous, active-high
//  w_opcode       in   7      IR[6:0]
//  w_funct3       in   3      IR[14:12]
//  w_funct7b5     in   1      IR[30]
//  w_zero         in   1      ALU result == 0
//  w_mem_ready    in   1      memory done this cycle (read data valid / write taken)
//  w_mem_req      out  1      memory access request
//  w_mem_write    out  1      request is a store
//  w_adr_src      out  1      0 = PC, 1 = ALUOut as memory address
//  w_ir_write     out  1      latch IR and oldPC
//  w_pc_write     out  1      load PC from result bus (datapath clears bit0)
//  w_reg_write    out  1      write rd from result bus
//  w_alu_src_a    out  2      00 PC, 01 oldPC, 10 rs1
//  w_alu_src_b    out  2      00 rs2, 01 imm, 10 const 4
//  w_alu_control  out  3      000 add, 001 sub, 010 and, 011 or, 100 pass b, 101 slt
//  w_result_src   out  2      00 ALUOut, 01 mem data, 10 ALU result
//  w_state        out  4      current state code (debug)
//  w_retired      out  CNT_W  retired instruction count
//  w_illegal      out  1      sticky trap flag
// BEHAVIOUR
//  States: 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMREAD, 4 MEMWB, 5 MEMWRITE, 6 EXER, 7 EXEI, 8 ALUWB,
//   9 BRANCH, 10 JAL, 11 JALR, 12 LINK, 13 UPPER, 14 TRAP. Unlisted outputs are 0 in each state.
//  Reset (async): state=FETCH, retired=0, illegal=0, wait counter=0. All outputs 0 while w_rst is high.
//  FETCH: mem_req=1, adr_src=0. Hold until mem_ready. In the ready cycle also assert ir_write=1,
//   pc_write=1, a=00, b=10, add, result_src=10. Then go to DECODE.
//  DECODE: a=01, b=01, add (ALUOut <= oldPC+imm). Dispatch on opcode:
//   0000011/0100011 -> MEMADR; 0110011 -> EXER; 0010011 -> EXEI; 1100011 -> BRANCH; 1101111 -> JAL;
//   1100111 -> JALR; 0110111/0010111 -> UPPER; anything else -> TRAP.
//  MEMADR: a=10, b=01, add. Go to MEMREAD if opcode[5]=0, else MEMWRITE.
//  MEMREAD: mem_req=1, adr_src=1. Hold until mem_ready, then go to MEMWB.
//  MEMWB: result_src=01, reg_write=1, then FETCH.
//  MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Hold until mem_ready, then FETCH.
//  EXER/EXEI: a=10, b=00 (R) or 01 (I). ALU code from funct3:
//   111 and, 110 or, 010 slt, 000 add (sub only when EXER and funct7b5=1), others add. Then ALUWB.
//  ALUWB: result_src=00, reg_write=1, then FETCH.
//  BRANCH: a=10, b=00, sub, result_src=00. pc_write = (f3==000 & zero) | (f3==001 & ~zero).
//   Other funct3 never taken. Then FETCH.
//  JAL: result_src=00, pc_write=1, then LINK.
//  JALR: a=10, b=01, add, result_src=10, pc_write=1, then LINK.
//  LINK: a=01, b=10, add, result_src=10, reg_write=1 (rd=oldPC+4), then FETCH.
//  UPPER: b=01, alu 100 (LUI) or a=01 add (AUIPC), result_src=10, reg_write=1, then FETCH.
//  TRAP: all enables 0, illegal=1. Stays in TRAP until reset.
//  Latency with zero-wait memory: branch/LUI/AUIPC 3 cycles; R/I/sw 4; JAL/JALR 4; lw 5.
//   Each mem_ready-low cycle adds one.
//  retired increments on every transition into FETCH from a non-FETCH state. Wraps silently.
//  Timeout (MEM_TIMEOUT>0): wait counter clears on state entry and counts cycles with mem_req & ~mem_ready.
//   When it reaches MEM_TIMEOUT, go to TRAP. A ready arriving in that same cycle wins.
//  mem_ready is ignored in every state without mem_req.
// TESTING
//  add (0110011, f3 000, b5 0), ready=1 -> states 0,1,6,8,0; alu 000; reg_write only in 8; retired 0->1.
//  sub (b5=1) -> alu 001 in EXER; addi with b5=1 -> alu 000 in EXEI.
//  lw, ready low 3 cycles in MEMREAD -> state 3 held 4 cycles with mem_req=1, adr_src=1; MEMWB reg_write 1 cycle.
//  beq zero=1 -> pc_write=1 in BRANCH; bne zero=1 -> pc_write=0; both return to FETCH, retired +1.
//  JALR -> 0,1,11,12,0; pc_write in 11 only, reg_write in 12 only with a=01, b=10.
//  opcode 0000000 -> TRAP, illegal=1, retired frozen. MEM_TIMEOUT=8, ready low -> TRAP after 8 FETCH cycles.
//  Reset asserted mid-MEMREAD -> outputs 0 immediately; after release state=0, retired=0.

Source files
------------

// File: rtl/m_multicycle_ctrl.sv
// m_multicycle_ctrl
//   Multicycle control FSM for the RV32I-subset datapath (register file, ALU,
//   immediate generator and a single shared memory). Each instruction is
//   sequenced over several cycles. The FSM drives the datapath mux selects,
//   the write enables and the ALU operation code. It handshakes with the
//   shared memory and counts retired instructions. It traps on an illegal
//   opcode, or on a memory access that waits too long when MEM_TIMEOUT is
//   non-zero.
//
// Parameters
//   CNT_W        width of the retired-instruction counter (wraps)
//   MEM_TIMEOUT  cycles a memory request may wait for ready before trapping;
//                0 disables the timeout
//
// Ports
//   w_clk, w_rst     clock (rising edge), async active-high reset
//   w_opcode         IR[6:0]
//   w_funct3         IR[14:12]
//   w_funct7b5       IR[30]
//   w_zero           ALU result is zero
//   w_mem_ready      memory completes the current request this cycle
//   w_mem_req        memory request
//   w_mem_write      request is a store
//   w_adr_src        memory address: 0 PC, 1 ALUOut
//   w_ir_write       latch IR and oldPC
//   w_pc_write       load PC from the result bus
//   w_reg_write      write rd from the result bus
//   w_alu_src_a      00 PC, 01 oldPC, 10 rs1
//   w_alu_src_b      00 rs2, 01 imm, 10 constant 4
//   w_alu_control    000 add, 001 sub, 010 and, 011 or, 100 pass b, 101 slt
//   w_result_src     00 ALUOut, 01 memory data, 10 ALU result
//   w_state          current state code (debug)
//   w_retired        retired instruction count
//   w_illegal        sticky trap flag
module m_multicycle_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic             w_clk,
  input  logic             w_rst,
  input  logic [6:0]       w_opcode,
  input  logic [2:0]       w_funct3,
  input  logic             w_funct7b5,
  input  logic             w_zero,
  input  logic             w_mem_ready,
  output logic             w_mem_req,
  output logic             w_mem_write,
  output logic             w_adr_src,
  output logic             w_ir_write,
  output logic             w_pc_write,
  output logic             w_reg_write,
  output logic [1:0]       w_alu_src_a,
  output logic [1:0]       w_alu_src_b,
  output logic [2:0]       w_alu_control,
  output logic [1:0]       w_result_src,
  output logic [3:0]       w_state,
  output logic [CNT_W-1:0] w_retired,
  output logic             w_illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXER     = 4'd6,
    S_EXEI     = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LINK     = 4'd12,
    S_UPPER    = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_PASS = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_IMM   = 2'b01;
  localparam logic [1:0] SRC_B_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEM     = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  state_t           state;
  state_t           state_nx;
  logic [31:0]      wait_cnt;
  logic [CNT_W-1:0] retired;
  logic             illegal;
  logic             timeout;

  // ALU operation for the execute states. Only R-type uses funct7b5 to
  // select subtract; I-type addi ignores it.
  function automatic logic [2:0] exe_alu(input logic [2:0] f3,
                                         input logic       is_r,
                                         input logic       b5);
    logic [2:0] op;
    op = ALU_ADD;
    case (f3)
      3'b111: op = ALU_AND;
      3'b110: op = ALU_OR;
      3'b010: op = ALU_SLT;
      3'b000: op = (is_r && b5) ? ALU_SUB : ALU_ADD;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // A request that is still stalled when the wait counter reaches the limit
  // traps. A ready arriving in the same cycle completes the access instead.
  always_comb begin
    timeout = 1'b0;
    if (MEM_TIMEOUT != 0) begin
      timeout = w_mem_req && !w_mem_ready && (wait_cnt == MEM_TIMEOUT - 1);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:    if (w_mem_ready) state_nx = S_DECODE;
      S_DECODE: begin
        case (w_opcode)
          OP_LOAD, OP_STORE: state_nx = S_MEMADR;
          OP_R:              state_nx = S_EXER;
          OP_I:              state_nx = S_EXEI;
          OP_BR:             state_nx = S_BRANCH;
          OP_JAL:            state_nx = S_JAL;
          OP_JALR:           state_nx = S_JALR;
          OP_LUI, OP_AUIPC:  state_nx = S_UPPER;
          default:           state_nx = S_TRAP;
        endcase
      end
      S_MEMADR:   state_nx = w_opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (w_mem_ready) state_nx = S_MEMWB;
      S_MEMWB:    state_nx = S_FETCH;
      S_MEMWRITE: if (w_mem_ready) state_nx = S_FETCH;
      S_EXER:     state_nx = S_ALUWB;
      S_EXEI:     state_nx = S_ALUWB;
      S_ALUWB:    state_nx = S_FETCH;
      S_BRANCH:   state_nx = S_FETCH;
      S_JAL:      state_nx = S_LINK;
      S_JALR:     state_nx = S_LINK;
      S_LINK:     state_nx = S_FETCH;
      S_UPPER:    state_nx = S_FETCH;
      S_TRAP:     state_nx = S_TRAP;
      default:    state_nx = S_TRAP;
    endcase
    if (timeout) state_nx = S_TRAP;
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      retired  <= '0;
      illegal  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx != state) begin
        wait_cnt <= '0;
      end else if (MEM_TIMEOUT != 0 && w_mem_req && !w_mem_ready) begin
        wait_cnt <= wait_cnt + 1;
      end
      if (state_nx == S_FETCH && state != S_FETCH) begin
        retired <= retired + 1'b1;
      end
      if (state_nx == S_TRAP) begin
        illegal <= 1'b1;
      end
    end
  end

  // The outputs are decoded from the state combinationally. FETCH and BRANCH
  // must react to mem_ready and zero in the same cycle, so these outputs
  // cannot be registered. The whole decode is forced low while reset is high.
  always_comb begin
    w_mem_req     = 1'b0;
    w_mem_write   = 1'b0;
    w_adr_src     = 1'b0;
    w_ir_write    = 1'b0;
    w_pc_write    = 1'b0;
    w_reg_write   = 1'b0;
    w_alu_src_a   = SRC_A_PC;
    w_alu_src_b   = SRC_B_RS2;
    w_alu_control = ALU_ADD;
    w_result_src  = RES_ALUOUT;
    case (state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (w_mem_ready) begin
          w_ir_write   = 1'b1;
          w_pc_write   = 1'b1;
          w_alu_src_b  = SRC_B_FOUR;
          w_result_src = RES_ALU;
        end
      end
      S_DECODE: begin
        w_alu_src_a = SRC_A_OLDPC;
        w_alu_src_b = SRC_B_IMM;
      end
      S_MEMADR: begin
        w_alu_src_a = SRC_A_RS1;
        w_alu_src_b = SRC_B_IMM;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
      end
      S_MEMWB: begin
        w_result_src = RES_MEM;
        w_reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        w_adr_src   = 1'b1;
      end
      S_EXER: begin
        w_alu_src_a   = SRC_A_RS1;
        w_alu_src_b   = SRC_B_RS2;
        w_alu_control = exe_alu(w_funct3, 1'b1, w_funct7b5);
      end
      S_EXEI: begin
        w_alu_src_a   = SRC_A_RS1;
        w_alu_src_b   = SRC_B_IMM;
        w_alu_control = exe_alu(w_funct3, 1'b0, w_funct7b5);
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a   = SRC_A_RS1;
        w_alu_src_b   = SRC_B_RS2;
        w_alu_control = ALU_SUB;
        w_pc_write    = (w_funct3 == 3'b000 && w_zero) ||
                        (w_funct3 == 3'b001 && !w_zero);
      end
      S_JAL: begin
        w_pc_write = 1'b1;
      end
      S_JALR: begin
        w_alu_src_a  = SRC_A_RS1;
        w_alu_src_b  = SRC_B_IMM;
        w_result_src = RES_ALU;
        w_pc_write   = 1'b1;
      end
      S_LINK: begin
        w_alu_src_a  = SRC_A_OLDPC;
        w_alu_src_b  = SRC_B_FOUR;
        w_result_src = RES_ALU;
        w_reg_write  = 1'b1;
      end
      S_UPPER: begin
        w_alu_src_b  = SRC_B_IMM;
        w_result_src = RES_ALU;
        w_reg_write  = 1'b1;
        if (w_opcode == OP_LUI) begin
          w_alu_control = ALU_PASS;
        end else begin
          w_alu_src_a = SRC_A_OLDPC;
        end
      end
      default: ;
    endcase
    if (w_rst) begin
      w_mem_req     = 1'b0;
      w_mem_write   = 1'b0;
      w_adr_src     = 1'b0;
      w_ir_write    = 1'b0;
      w_pc_write    = 1'b0;
      w_reg_write   = 1'b0;
      w_alu_src_a   = '0;
      w_alu_src_b   = '0;
      w_alu_control = '0;
      w_result_src  = '0;
    end
  end

  assign w_state   = state;
  assign w_retired = retired;
  assign w_illegal = illegal;

endmodule

// File: tb/tb_m_multicycle_ctrl.sv
module tb_m_multicycle_ctrl;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] alu;
    logic [1:0] rs;
    logic [3:0] st;
  } vec_t;

  logic        w_clk;
  logic        w_rst;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_funct7b5;
  logic        w_zero;
  logic        w_mem_ready;
  logic        w_mem_req, w_mem_write, w_adr_src, w_ir_write, w_pc_write, w_reg_write;
  logic [1:0]  w_alu_src_a, w_alu_src_b, w_result_src;
  logic [2:0]  w_alu_control;
  logic [3:0]  w_state;
  logic [31:0] w_retired;
  logic        w_illegal;

  logic        rst2, rdy2;
  logic        mem_req2, mem_write2, adr_src2, ir_write2, pc_write2, reg_write2;
  logic [1:0]  a2, b2, rs2;
  logic [2:0]  alu2;
  logic [3:0]  state2;
  logic [7:0]  retired2;
  logic        illegal2;

  m_multicycle_ctrl dut (
    .w_clk(w_clk), .w_rst(w_rst), .w_opcode(w_opcode), .w_funct3(w_funct3),
    .w_funct7b5(w_funct7b5), .w_zero(w_zero), .w_mem_ready(w_mem_ready),
    .w_mem_req(w_mem_req), .w_mem_write(w_mem_write), .w_adr_src(w_adr_src),
    .w_ir_write(w_ir_write), .w_pc_write(w_pc_write), .w_reg_write(w_reg_write),
    .w_alu_src_a(w_alu_src_a), .w_alu_src_b(w_alu_src_b),
    .w_alu_control(w_alu_control), .w_result_src(w_result_src),
    .w_state(w_state), .w_retired(w_retired), .w_illegal(w_illegal)
  );

  m_multicycle_ctrl #(.CNT_W(8), .MEM_TIMEOUT(8)) dut_to (
    .w_clk(w_clk), .w_rst(rst2), .w_opcode(w_opcode), .w_funct3(w_funct3),
    .w_funct7b5(w_funct7b5), .w_zero(w_zero), .w_mem_ready(rdy2),
    .w_mem_req(mem_req2), .w_mem_write(mem_write2), .w_adr_src(adr_src2),
    .w_ir_write(ir_write2), .w_pc_write(pc_write2), .w_reg_write(reg_write2),
    .w_alu_src_a(a2), .w_alu_src_b(b2), .w_alu_control(alu2),
    .w_result_src(rs2), .w_state(state2), .w_retired(retired2),
    .w_illegal(illegal2)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  int   n_chk = 0;
  int   n_pass = 0;
  vec_t obs;
  vec_t exp_v;
  int   exp_ph;
  logic chk_en;
  int   m_ret;
  logic m_ill;
  int   cnt3;
  int   cnt_rw;

  assign obs = {w_mem_req, w_mem_write, w_adr_src, w_ir_write, w_pc_write,
                w_reg_write, w_alu_src_a, w_alu_src_b, w_alu_control,
                w_result_src, w_state};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  // Expected control word for a given phase of an instruction, from the
  // per-state output table (unlisted outputs are zero).
  function automatic vec_t exp_vec(input int ph, input logic [6:0] op,
                                   input logic [2:0] f3, input logic b5,
                                   input logic z, input logic rdy);
    vec_t v;
    v = '0;
    v.st = 4'(ph);
    case (ph)
      0: begin
        v.mem_req = 1;
        if (rdy) begin v.ir_write = 1; v.pc_write = 1; v.b = 2; v.rs = 2; end
      end
      1: begin v.a = 1; v.b = 1; end
      2: begin v.a = 2; v.b = 1; end
      3: begin v.mem_req = 1; v.adr_src = 1; end
      4: begin v.rs = 1; v.reg_write = 1; end
      5: begin v.mem_req = 1; v.mem_write = 1; v.adr_src = 1; end
      6, 7: begin
        v.a = 2;
        v.b = (ph == 7) ? 2'd1 : 2'd0;
        if (f3 == 3'b111) v.alu = 3'b010;
        else if (f3 == 3'b110) v.alu = 3'b011;
        else if (f3 == 3'b010) v.alu = 3'b101;
        else if (f3 == 3'b000 && ph == 6 && b5) v.alu = 3'b001;
        else v.alu = 3'b000;
      end
      8: v.reg_write = 1;
      9: begin
        v.a = 2; v.alu = 3'b001;
        v.pc_write = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z);
      end
      10: v.pc_write = 1;
      11: begin v.a = 2; v.b = 1; v.rs = 2; v.pc_write = 1; end
      12: begin v.a = 1; v.b = 2; v.rs = 2; v.reg_write = 1; end
      13: begin
        v.b = 1; v.rs = 2; v.reg_write = 1;
        if (op == 7'b0110111) v.alu = 3'b100;
        else v.a = 1;
      end
      default: ;
    endcase
    return v;
  endfunction

  always @(negedge w_clk) begin
    if (w_rst === 1'b0) begin
      if (w_state == 4'd3 && w_mem_req && w_adr_src) cnt3++;
      if (w_reg_write) cnt_rw++;
    end
    if (chk_en) begin
      chk($sformatf("outputs ph=%0d op=%b", exp_ph, w_opcode), 64'(obs), 64'(exp_v));
      chk("retired", 64'(w_retired), 64'(m_ret));
      chk("illegal", 64'(w_illegal), 64'(m_ill));
    end
  end

  task automatic step(input int ph, input logic rdy);
    w_mem_ready = rdy;
    exp_ph = ph;
    exp_v = exp_vec(ph, w_opcode, w_funct3, w_funct7b5, w_zero, rdy);
    chk_en = 1'b1;
    @(posedge w_clk); #1;
  endtask

  // Phase sequence of one instruction: fw stalled fetch cycles and mw stalled
  // data-memory cycles.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic b5, input logic z,
                           input int fw, input int mw);
    w_opcode = op; w_funct3 = f3; w_funct7b5 = b5; w_zero = z;
    for (int i = 0; i <= fw; i++) step(0, i == fw);
    step(1, 1'($urandom_range(0, 1)));
    case (op)
      7'b0000011: begin
        step(2, 1'($urandom_range(0, 1)));
        for (int i = 0; i <= mw; i++) step(3, i == mw);
        step(4, 1'($urandom_range(0, 1)));
      end
      7'b0100011: begin
        step(2, 1'($urandom_range(0, 1)));
        for (int i = 0; i <= mw; i++) step(5, i == mw);
      end
      7'b0110011: begin step(6, 1'b0); step(8, 1'b1); end
      7'b0010011: begin step(7, 1'b1); step(8, 1'b0); end
      7'b1100011: step(9, 1'($urandom_range(0, 1)));
      7'b1101111: begin step(10, 1'b0); step(12, 1'b1); end
      7'b1100111: begin step(11, 1'b1); step(12, 1'b0); end
      7'b0110111, 7'b0010111: step(13, 1'($urandom_range(0, 1)));
      default: begin
        m_ill = 1'b1;
        for (int i = 0; i < 5; i++) step(14, 1'($urandom_range(0, 1)));
        return;
      end
    endcase
    m_ret++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    w_rst = 0; rst2 = 0; rdy2 = 0; chk_en = 0;
    w_opcode = '0; w_funct3 = '0; w_funct7b5 = 0; w_zero = 0; w_mem_ready = 0;
    m_ret = 0; m_ill = 0; cnt3 = 0; cnt_rw = 0; exp_v = '0; exp_ph = 0;
    #1 w_rst = 1; rst2 = 1; w_mem_ready = 1;
    #2;
    chk("reset outputs", 64'(obs), 64'd0);
    chk("reset retired", 64'(w_retired), 64'd0);
    chk("reset illegal", 64'(w_illegal), 64'd0);
    @(posedge w_clk); #1;
    w_rst = 0;

    cnt_rw = 0;
    run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);   // add
    chk("add retired", 64'(w_retired), 64'd1);
    chk("add reg_write cycles", 64'(cnt_rw), 64'd1);
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);   // sub
    run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0);   // addi, b5 ignored
    run_instr(7'b0110011, 3'b111, 1'b0, 1'b0, 1, 0);   // and
    run_instr(7'b0010011, 3'b110, 1'b0, 1'b1, 0, 0);   // ori
    run_instr(7'b0010011, 3'b010, 1'b0, 1'b0, 0, 0);   // slti
    run_instr(7'b0110011, 3'b100, 1'b1, 1'b0, 0, 0);   // xor -> add
    cnt3 = 0; cnt_rw = 0;
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1, 3);   // lw, 3 stall cycles
    chk("lw MEMREAD cycles", 64'(cnt3), 64'd4);
    chk("lw reg_write cycles", 64'(cnt_rw), 64'd1);
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 1);   // sw
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);   // beq taken
    run_instr(7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0);   // bne not taken
    run_instr(7'b1100011, 3'b001, 1'b0, 1'b0, 0, 0);   // bne taken
    run_instr(7'b1100011, 3'b100, 1'b0, 1'b1, 0, 0);   // blt never taken
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0);   // jal
    cnt_rw = 0;
    run_instr(7'b1100111, 3'b000, 1'b0, 1'b0, 0, 0);   // jalr
    chk("jalr reg_write cycles", 64'(cnt_rw), 64'd1);
    run_instr(7'b0110111, 3'b000, 1'b0, 1'b0, 0, 0);   // lui
    run_instr(7'b0010111, 3'b000, 1'b0, 1'b0, 2, 0);   // auipc
    chk("retired after 17", 64'(w_retired), 64'd17);

    // Reset in the middle of a stalled load.
    w_opcode = 7'b0000011; w_funct3 = 3'b010;
    step(0, 1'b1); step(1, 1'b1); step(2, 1'b1); step(3, 1'b0); step(3, 1'b0);
    chk_en = 0;
    w_rst = 1;
    #1;
    chk("mid-read reset outputs", 64'(obs), 64'd0);
    chk("mid-read reset retired", 64'(w_retired), 64'd0);
    @(posedge w_clk); #1;
    w_rst = 0; m_ret = 0; m_ill = 0;
    chk("post-reset state", 64'(w_state), 64'd0);
    run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);
    chk("post-reset retired", 64'(w_retired), 64'd1);

    run_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0);   // illegal
    chk("trap state", 64'(w_state), 64'd14);
    chk("trap illegal", 64'(w_illegal), 64'd1);
    chk("trap retired frozen", 64'(w_retired), 64'd1);
    chk_en = 0;

    // Timeout instance: fetch never gets ready.
    rdy2 = 0;
    rst2 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge w_clk);
      chk($sformatf("timeout fetch %0d", i), 64'({state2, mem_req2}), 64'({4'd0, 1'b1}));
      @(posedge w_clk); #1;
    end
    chk("timeout state", 64'(state2), 64'd14);
    chk("timeout illegal", 64'(illegal2), 64'd1);
    chk("timeout mem_req", 64'(mem_req2), 64'd0);
    chk("timeout retired", 64'(retired2), 64'd0);

    // Ready in the limit cycle completes the fetch.
    rst2 = 1; #1; rst2 = 0;
    for (int i = 0; i < 8; i++) begin
      rdy2 = (i == 7);
      @(negedge w_clk);
      if (i == 7) chk("late ready ir_write", 64'(ir_write2), 64'd1);
      @(posedge w_clk); #1;
    end
    chk("late ready state", 64'(state2), 64'd1);
    chk("late ready illegal", 64'(illegal2), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
